ch_test_seq: RTL and testbench

Sequencer for the channel bench's transmit/receive test path. It drives the NRZ bit stream into the bit-to-PWL driver: idle level, then an alternating preamble, then a PRBS7 payload. It self-synchronises a PRBS7 checker on the sliced receiver bit, counts bit errors over a fixed measurement window, and gates the PWL probe capture window. It replaces free-running PRBS stimulus so that channel runs start, lock, measure and terminate deterministically.

---
 rtl/ch_test_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_ch_test_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ch_test_seq.sv
// ch_test_seq -- channel bench transmit/receive test sequencer.
//
// Drives an NRZ stream into the bit-to-PWL driver: idle level, then an
// alternating 1/0 preamble, then a PRBS7 payload (x^7+x^6+1). A
// self-synchronising PRBS7 checker watches the sliced receiver bit. It
// declares lock after LOCK_CNT consecutive matches, then counts bit errors
// over PAYLOAD_LEN compared bits. The block also gates the probe capture
// window, so every run starts, locks, measures and terminates
// deterministically.
//
// Optional feature macro: CH_TEST_SEQ_INJECT_EN
//   defined   : inj_err sampled high in MEASURE inverts the next transmitted
//               bit for one cycle; the LFSR state is left undisturbed.
//   undefined : inj_err is ignored.
//
// Ports
//   clk      in   bit clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   begins a run when sampled in IDLE or DONE
//   abort    in   returns any non-IDLE state to IDLE on the next edge
//   rx_bit   in   sliced channel output
//   inj_err  in   error-injection request
//   tx_bit   out  bit to the bit-to-PWL driver
//   cap_en   out  probe capture window (LOCK, MEASURE)
//   busy     out  run in progress (PREAMBLE, LOCK, MEASURE)
//   done     out  run finished (DONE)
//   lock     out  checker locked (from lock declaration until MEASURE ends)
//   fail     out  run ended on lock timeout
//   err_cnt  out  saturating MEASURE error count
//   state    out  current state encoding, for debug
module ch_test_seq #(
    parameter int PREAMBLE_LEN = 32,
    parameter int LOCK_CNT     = 16,
    parameter int LOCK_TIMEOUT = 512,
    parameter int PAYLOAD_LEN  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        rx_bit,
    input  logic        inj_err,
    output logic        tx_bit,
    output logic        cap_en,
    output logic        busy,
    output logic        done,
    output logic        lock,
    output logic        fail,
    output logic [15:0] err_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_LOCK     = 3'd2,
        ST_MEASURE  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [6:0]  LFSR_SEED = 7'h7F;
    // One shared cycle counter serves PREAMBLE, LOCK and MEASURE; it is
    // cleared on every state change, so each phase counts from zero.
    localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] TO_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] PAY_LAST  = 16'(PAYLOAD_LEN - 1);
    localparam logic [7:0]  RUN_LAST  = 8'(LOCK_CNT - 1);

    state_t      state_q, state_d;
    logic        tx_q, cap_q, busy_q, done_q, lock_q, fail_q;
    logic [15:0] err_q;
    logic [6:0]  lfsr_q;
    logic [6:0]  rxsr_q;
    logic [15:0] cnt_q;
    logic [7:0]  run_q;
    logic [2:0]  ld_q;

    logic [6:0]  lfsr_step_d;
    logic        pred_d;
    logic        loaded_d;
    logic        match_d;
    logic        mismatch_d;
    logic        start_run_d;
    logic        inj_flip_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign lfsr_step_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

    // The checker predicts the incoming bit from the two bits that fed the
    // transmitter's feedback seven and six bits ago. Predictions are only
    // trusted once seven received bits of the current run fill rxsr.
    assign pred_d      = rxsr_q[6] ^ rxsr_q[5];
    assign loaded_d    = (ld_q == 3'd7);
    assign match_d     = loaded_d && (rx_bit == pred_d);
    assign mismatch_d  = loaded_d && (rx_bit != pred_d);
    assign start_run_d = (state_d == ST_PREAMBLE) && (state_q != ST_PREAMBLE);

`ifdef CH_TEST_SEQ_INJECT_EN
    assign inj_flip_d = (state_q == ST_MEASURE) && inj_err;
`else
    logic unused_inj;
    assign unused_inj = inj_err;
    assign inj_flip_d = 1'b0;
`endif

    // Next-state selection. abort has top priority everywhere except IDLE.
    // In LOCK a lock declaration beats a timeout on the same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (abort)                  state_d = ST_IDLE;
                else if (cnt_q == PRE_LAST) state_d = ST_LOCK;
            end
            ST_LOCK: begin
                if (abort)                             state_d = ST_IDLE;
                else if (match_d && run_q == RUN_LAST) state_d = ST_MEASURE;
                else if (cnt_q == TO_LAST)             state_d = ST_DONE;
            end
            ST_MEASURE: begin
                if (abort)                  state_d = ST_IDLE;
                else if (cnt_q == PAY_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (abort)      state_d = ST_IDLE;
                else if (start) state_d = ST_PREAMBLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b0;
            cap_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= 16'd0;
            lfsr_q  <= LFSR_SEED;
            rxsr_q  <= 7'd0;
            cnt_q   <= 16'd0;
            run_q   <= 8'd0;
            ld_q    <= 3'd0;
        end else begin
            state_q <= state_d;

            // Status outputs are registered from the next state so they line
            // up with the state they describe.
            cap_q  <= (state_d == ST_LOCK) || (state_d == ST_MEASURE);
            busy_q <= (state_d == ST_PREAMBLE) || (state_d == ST_LOCK) ||
                      (state_d == ST_MEASURE);
            done_q <= (state_d == ST_DONE);

            if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_DONE))
                cnt_q <= 16'd0;
            else
                cnt_q <= cnt_q + 16'd1;

            // tx_q always presents lfsr_q[6] (possibly inverted) in PRBS
            // states; the seed is loaded on the edge that enters LOCK so the
            // first LOCK cycle already carries the first PRBS bit.
            unique case (state_d)
                ST_IDLE: begin
                    tx_q <= 1'b0;
                end
                ST_PREAMBLE: begin
                    tx_q <= (state_q == ST_PREAMBLE) ? ~tx_q : 1'b1;
                end
                ST_LOCK: begin
                    if (state_q == ST_PREAMBLE) begin
                        lfsr_q <= LFSR_SEED;
                        tx_q   <= LFSR_SEED[6];
                    end else begin
                        lfsr_q <= lfsr_step_d;
                        tx_q   <= lfsr_step_d[6];
                    end
                end
                default: begin
                    // MEASURE and DONE: the LFSR keeps running so the channel
                    // tail stays PRBS. Injection flips only the output bit.
                    lfsr_q <= lfsr_step_d;
                    tx_q   <= lfsr_step_d[6] ^ inj_flip_d;
                end
            endcase

            if ((state_q == ST_LOCK) || (state_q == ST_MEASURE)) begin
                rxsr_q <= {rxsr_q[5:0], rx_bit};
                if (!loaded_d) ld_q <= ld_q + 3'd1;
            end else begin
                ld_q <= 3'd0;
            end

            if ((state_q == ST_LOCK) && (state_d == ST_LOCK)) begin
                if (match_d)         run_q <= run_q + 8'd1;
                else if (mismatch_d) run_q <= 8'd0;
            end else begin
                run_q <= 8'd0;
            end

            // abort leaves err_cnt untouched; only a new run clears it.
            if (start_run_d)
                err_q <= 16'd0;
            else if ((state_q == ST_MEASURE) && (state_d != ST_IDLE) && mismatch_d)
                err_q <= sat_inc(err_q);

            if (start_run_d || (state_d == ST_IDLE))
                fail_q <= 1'b0;
            else if ((state_q == ST_LOCK) && (state_d == ST_DONE))
                fail_q <= 1'b1;

            if ((state_q == ST_LOCK) && (state_d == ST_MEASURE))
                lock_q <= 1'b1;
            else if (state_d != ST_MEASURE)
                lock_q <= 1'b0;
        end
    end

    assign tx_bit  = tx_q;
    assign cap_en  = cap_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign lock    = lock_q;
    assign fail    = fail_q;
    assign err_cnt = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_ch_test_seq.sv
module tb_ch_test_seq;

    localparam int PREAMBLE_LEN = 32;
    localparam int LOCK_CNT     = 16;
    localparam int LOCK_TIMEOUT = 512;
    localparam int PAYLOAD_LEN  = 1024;

`ifdef CH_TEST_SEQ_INJECT_EN
    localparam int INJ_ERRS = 3;
    localparam bit INJ_ON   = 1'b1;
`else
    localparam int INJ_ERRS = 0;
    localparam bit INJ_ON   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rx_bit = 1'b0;
    logic        inj_err = 1'b0;
    logic        tx_bit, cap_en, busy, done, lock, fail;
    logic [15:0] err_cnt;
    logic [2:0]  state;

    ch_test_seq #(
        .PREAMBLE_LEN(PREAMBLE_LEN),
        .LOCK_CNT(LOCK_CNT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .PAYLOAD_LEN(PAYLOAD_LEN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rx_bit(rx_bit), .inj_err(inj_err),
        .tx_bit(tx_bit), .cap_en(cap_en), .busy(busy), .done(done),
        .lock(lock), .fail(fail), .err_cnt(err_cnt), .state(state)
    );

    always #5 clk = ~clk;

    // Channel model: 0 = loopback through ch_dly cycles, 1 = tied 0,
    // 2 = tied 1, 3 = tied 1 for the first ch_sw LOCK cycles then tied 0.
    // ch_inv flips the received bit at MEASURE cycles 50, 150, ... 950.
    typedef struct {
        int mode; int dly; int sw; bit inv; int inj_n;
        int exp_err; bit exp_fail; int exp_lk;
    } vec_t;
    typedef struct { int err; bit fail; int lk; int meas; } exp_t;

    int          ch_mode, ch_dly, ch_sw;
    bit          ch_inv;
    logic [15:0] hist = '0;
    int          ch_l, ch_m;
    bit          pb [0:2047];
    exp_t        sbq [$];
    vec_t        tbl [7];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge, then present this cycle's rx_bit.
    task automatic cycle();
        int li, mi;
        logic r;
        @(negedge clk);
        hist = {hist[14:0], tx_bit};
        li = 0;
        mi = 0;
        if (state == 3'd2) begin li = ch_l; ch_l++; end else ch_l = 0;
        if (state == 3'd3) begin mi = ch_m; ch_m++; end else ch_m = 0;
        case (ch_mode)
            0:       r = hist[ch_dly];
            1:       r = 1'b0;
            2:       r = 1'b1;
            default: r = (state == 3'd2 && li < ch_sw) ? 1'b1 : 1'b0;
        endcase
        if (ch_inv && state == 3'd3 && (mi % 100) == 50) r = ~r;
        rx_bit = r;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   pre, lk, ms, n, pre_bad, prbs_bad, st_bad;
        bit   inv_next, fin;
        ch_mode = v.mode; ch_dly = v.dly; ch_sw = v.sw; ch_inv = v.inv;
        e.err  = v.exp_err;
        e.fail = v.exp_fail;
        e.lk   = v.exp_lk;
        e.meas = v.exp_fail ? 0 : PAYLOAD_LEN;
        sbq.push_back(e);

        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_state", 32'(state), 32'd1);
        chk("start_err_clr", 32'(err_cnt), 32'd0);
        chk("start_fail_clr", 32'(fail), 32'd0);

        pre = 0; lk = 0; ms = 0; n = 0;
        pre_bad = 0; prbs_bad = 0; st_bad = 0;
        inv_next = 1'b0; fin = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (state == 3'd4) begin fin = 1'b1; break; end
            case (state)
                3'd1: begin
                    if (tx_bit !== ((pre % 2) == 0)) pre_bad++;
                    if (cap_en !== 1'b0 || busy !== 1'b1) st_bad++;
                    pre++;
                end
                3'd2: begin
                    if (tx_bit !== pb[n]) prbs_bad++;
                    if (lock !== 1'b0 || cap_en !== 1'b1 || busy !== 1'b1) st_bad++;
                    n++; lk++;
                end
                3'd3: begin
                    if (tx_bit !== (pb[n] ^ inv_next)) prbs_bad++;
                    if (lock !== 1'b1 || cap_en !== 1'b1 || busy !== 1'b1) st_bad++;
                    n++;
                end
                default: st_bad++;
            endcase
            if (state == 3'd3) begin
                inj_err  = ((ms % 200) == 100) && ((ms / 200) < v.inj_n);
                inv_next = INJ_ON && inj_err;
                ms++;
            end else begin
                inj_err  = 1'b0;
                inv_next = 1'b0;
            end
            cycle();
        end
        inj_err = 1'b0;
        chk("run_reaches_done", 32'(fin), 32'd1);

        e = sbq.pop_front();
        chk("done_err_cnt", 32'(err_cnt), 32'(e.err));
        chk("done_fail", 32'(fail), 32'(e.fail));
        chk("done_flags", 32'({done, busy, cap_en, lock}), 32'b1000);
        chk("done_tx_prbs", 32'(tx_bit), 32'(pb[n]));
        chk("preamble_len", 32'(pre), 32'(PREAMBLE_LEN));
        chk("preamble_bits", 32'(pre_bad), 32'd0);
        chk("prbs_bits", 32'(prbs_bad), 32'd0);
        chk("phase_flags", 32'(st_bad), 32'd0);
        chk("measure_len", 32'(ms), 32'(e.meas));
        if (e.lk >= 0) chk("lock_len", 32'(lk), 32'(e.lk));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ms;
        bit  hit;
        // Reference PRBS7: seed 7F gives seven leading ones, then
        // b[n] = b[n-7] ^ b[n-6].
        for (int i = 0; i < 2048; i++)
            pb[i] = (i < 7) ? 1'b1 : (pb[i-7] ^ pb[i-6]);

        //           mode dly  sw  inv inj err            fail  lk
        tbl[0] = '{0, 0, 0,   1'b0, 0, 0,             1'b0, 7 + LOCK_CNT};
        tbl[1] = '{1, 0, 0,   1'b0, 0, 0,             1'b0, 7 + LOCK_CNT};
        tbl[2] = '{2, 0, 0,   1'b0, 0, 0,             1'b1, LOCK_TIMEOUT};
        tbl[3] = '{0, 5, 0,   1'b1, 0, 30,            1'b0, -1};
        tbl[4] = '{0, 0, 0,   1'b0, 4, 4 * INJ_ERRS,  1'b0, 7 + LOCK_CNT};
        tbl[5] = '{3, 0, 489, 1'b0, 0, 0,             1'b0, LOCK_TIMEOUT};
        tbl[6] = '{3, 0, 490, 1'b0, 0, 0,             1'b1, LOCK_TIMEOUT};

        ch_mode = 0; ch_dly = 0; ch_sw = 0; ch_inv = 1'b0;
        ch_l = 0; ch_m = 0;

        #2;
        chk("reset_outputs", 32'({state, tx_bit, cap_en, busy, done, lock, fail, err_cnt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("idle_after_reset", 32'({state, tx_bit, busy}), 32'd0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // abort from DONE returns to IDLE and keeps the count.
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_done_state", 32'(state), 32'd0);
        chk("abort_done_err", 32'(err_cnt), 32'(4 * INJ_ERRS * 0));

        // abort mid-MEASURE with delayed loopback and flipped bits: six
        // flip events (MEASURE cycles 50..550) precede cycle 600.
        ch_mode = 0; ch_dly = 5; ch_inv = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        ms = 0; hit = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (state == 3'd3 && ms == 600) begin hit = 1'b1; break; end
            if (state == 3'd3) ms++;
            cycle();
        end
        chk("abort_reach_measure", 32'(hit), 32'd1);
        chk("pre_abort_lock", 32'(lock), 32'd1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_outputs", 32'({tx_bit, cap_en, busy, lock, done}), 32'd0);
        chk("abort_err_hold", 32'(err_cnt), 32'd18);
        cycle();
        cycle();
        chk("idle_err_hold", 32'(err_cnt), 32'd18);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("restart_err_clr", 32'(err_cnt), 32'd0);
        chk("restart_first_bit", 32'({state, tx_bit}), 32'b0011);

        // Asynchronous reset between edges in PREAMBLE.
        cycle();
        cycle();
        #1 rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({state, tx_bit, cap_en, busy, done, lock, fail, err_cnt}), 32'd0);
        #1 rst = 1'b0;
        cycle();
        chk("post_reset_idle", 32'(state), 32'd0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("post_reset_pre_bit0", 32'({state, tx_bit}), 32'b0011);
        cycle();
        chk("post_reset_pre_bit1", 32'(tx_bit), 32'd0);
        cycle();
        chk("post_reset_pre_bit2", 32'(tx_bit), 32'd1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("final_abort_idle", 32'({state, tx_bit}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
